// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link (transmitter and receiver).
// Button bit positions follow the receiver word layout {B, A, 9..0}.
package joy_db15_pkg;

    localparam int JOY_W          = 12;
    localparam int FRAME_BITS_DEF = 2 * JOY_W;

    localparam int J_R      = 0;
    localparam int J_L      = 1;
    localparam int J_D      = 2;
    localparam int J_U      = 3;
    localparam int J_START  = 4;
    localparam int J_SELECT = 5;
    localparam int J_X      = 6;
    localparam int J_Y      = 7;
    localparam int J_Z      = 8;
    localparam int J_MODE   = 9;
    localparam int J_A      = 10;
    localparam int J_B      = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } joy_state_e;

endpackage

// File: rtl/joy_db15_tx_sync.sv
// Multi-stage synchroniser for an asynchronous pin, followed by a registered
// edge detector. Everything resets to 1 (the inactive pin level).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its neighbours; blocking = here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick responder: snapshots {joystick2, joystick1} while JOY_LOAD is low
// and shifts it out active-low, one bit per JOY_CLK rising edge.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int   FRAME_BITS  = FRAME_BITS_DEF,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_FILL   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [JOY_W-1:0] joystick1,
    input  logic [JOY_W-1:0] joystick2,
    input  logic             joy_clk,
    input  logic             joy_load,
    output logic             joy_data,
    output logic             frame_done,
    output logic             short_frame
);

    localparam int POS_W = $clog2(FRAME_BITS + 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] PEN_POS  = POS_W'(FRAME_BITS - 2);

    logic clk_level_unused, clk_rise, clk_fall_unused;
    logic load_level, load_rise, load_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (joy_clk),
        .level (clk_level_unused),
        .rise  (clk_rise),
        .fall  (clk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (joy_load),
        .level (load_level),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    logic [2*JOY_W-1:0]      frame;
    joy_state_e              state, state_nxt;
    logic [POS_W-1:0]        pos, pos_nxt;
    logic [FRAME_BITS-1:0]   snapshot, snapshot_nxt;
    logic                    joy_data_nxt, frame_done_nxt, short_frame_nxt;

    assign frame = {joystick2, joystick1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pos         <= '0;
            snapshot    <= '1;
            joy_data    <= IDLE_FILL;
            frame_done  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            snapshot    <= snapshot_nxt;
            joy_data    <= joy_data_nxt;
            frame_done  <= frame_done_nxt;
            short_frame <= short_frame_nxt;
        end
    end

    // The snapshot shifts toward bit 0, so snapshot[1] is always the next bit out.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt       = state;
        pos_nxt         = pos;
        snapshot_nxt    = snapshot;
        joy_data_nxt    = joy_data;
        frame_done_nxt  = 1'b0;
        short_frame_nxt = short_frame;

        if (!load_level) begin
            // Load has priority over any coincident joy_clk edge.
            if (state == SHIFT && load_fall && pos < LAST_POS)
                short_frame_nxt = 1'b1;
            state_nxt    = LOAD;
            pos_nxt      = '0;
            snapshot_nxt = ~frame[FRAME_BITS-1:0];
            joy_data_nxt = ~frame[0];
        end else begin
            unique case (state)
                IDLE: joy_data_nxt = IDLE_FILL;
                LOAD: begin
                    if (load_rise)
                        state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (clk_rise) begin
                        pos_nxt      = pos + 1'b1;
                        snapshot_nxt = {IDLE_FILL, snapshot[FRAME_BITS-1:1]};
                        if (pos == LAST_POS) begin
                            state_nxt    = DONE;
                            joy_data_nxt = IDLE_FILL;
                        end else begin
                            joy_data_nxt   = snapshot[1];
                            frame_done_nxt = (pos == PEN_POS);
                        end
                    end
                end
                DONE: joy_data_nxt = IDLE_FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: expected serial bits are queued when a frame
// is loaded and compared as the initiator samples joy_data before each clock.
module tb_joy_db15_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] joystick1, joystick2;
    logic        joy_clk, joy_load;
    logic        joy_data, frame_done, short_frame;

    int n_checks = 0;
    int n_errors = 0;
    int fd_total = 0;
    logic exp_q[$];

    joy_db15_tx dut (
        .clk         (clk),
        .reset       (reset),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joy_data    (joy_data),
        .frame_done  (frame_done),
        .short_frame (short_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_total++;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_pulse();
        joy_clk = 1'b1;
        wait_clks(8);
        joy_clk = 1'b0;
        wait_clks(8);
    endtask

    task automatic sample(input string tag);
        logic e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
        check(tag, {31'd0, joy_data}, {31'd0, e});
    endtask

    // Load a frame, then apply n_edges joy_clk pulses; joystick1 becomes j1_mid after edge 12.
    task automatic send_frame(input string tag, input logic [11:0] j1, input logic [11:0] j2,
                              input int n_edges, input logic [11:0] j1_mid);
        logic [23:0] f;
        int base;
        f = {j2, j1};
        for (int k = 0; k <= n_edges; k++)
            exp_q.push_back(k < 24 ? ~f[k] : 1'b1);
        joystick1 = j1;
        joystick2 = j2;
        joy_load  = 1'b0;
        wait_clks(10);
        joy_load  = 1'b1;
        wait_clks(8);
        base = fd_total;
        sample($sformatf("%s_b0", tag));
        for (int e = 1; e <= n_edges; e++) begin
            clk_pulse();
            if (e == 12) joystick1 = j1_mid;
            sample($sformatf("%s_b%0d", tag, e));
            if (e == 22) check($sformatf("%s_fd_early", tag), fd_total - base, 0);
            if (e == 23) check($sformatf("%s_fd_last", tag), fd_total - base, 1);
        end
        check($sformatf("%s_fd_total", tag), fd_total - base, (n_edges >= 23) ? 1 : 0);
    endtask

    initial begin
        reset     = 1'b1;
        joy_clk   = 1'b0;
        joy_load  = 1'b1;
        joystick1 = '0;
        joystick2 = '0;
        wait_clks(4);
        check("rst_data", {31'd0, joy_data}, 1);
        check("rst_fd", {31'd0, frame_done}, 0);
        check("rst_short", {31'd0, short_frame}, 0);
        reset = 1'b0;
        wait_clks(4);

        // Clocks without a load: idle level, no frame_done, no short_frame.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(1'b1);
            clk_pulse();
            sample($sformatf("idle_%0d", i));
        end
        check("idle_fd", fd_total, 0);
        check("idle_short", {31'd0, short_frame}, 0);

        // First and last bit pressed, plus a 25th edge after the frame.
        send_frame("f1", 12'h001, 12'h800, 25, 12'h001);
        check("f1_short", {31'd0, short_frame}, 0);

        // joystick1 all pressed; changing it mid-shift must not affect the stream.
        send_frame("f2", 12'hFFF, 12'h000, 24, 12'h000);
        check("f2_short", {31'd0, short_frame}, 0);

        // Short frame: reload after 5 edges, coincident with a joy_clk rising edge.
        send_frame("sf", 12'h001, 12'h000, 5, 12'h001);
        joy_load = 1'b0;
        joy_clk  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("lat_pre", {31'd0, joy_data}, 1);
        @(posedge clk);
        #1 check("lat_hit", {31'd0, joy_data}, 0);
        wait_clks(6);
        check("sim_noshift", {31'd0, joy_data}, 0);
        check("sf_short", {31'd0, short_frame}, 1);
        joy_clk = 1'b0;
        wait_clks(8);
        send_frame("f3", 12'h5A3, 12'hC36, 24, 12'h5A3);
        check("f3_short_sticky", {31'd0, short_frame}, 1);

        // Reset in the middle of a frame, while a pressed bit is on the pin.
        send_frame("mid", 12'h400, 12'h000, 10, 12'h400);
        reset = 1'b1;
        @(posedge clk);
        #1 check("midrst_data", {31'd0, joy_data}, 1);
        check("midrst_short", {31'd0, short_frame}, 0);
        check("midrst_fd", {31'd0, frame_done}, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_clks(10);
        check("post_rst_idle", {31'd0, joy_data}, 1);
        send_frame("f4", 12'hA5C, 12'h3C9, 24, 12'hA5C);
        check("f4_short", {31'd0, short_frame}, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
